aes_inv_sub_bytes_seq: RTL and testbench

// Sequences a full 128-bit AES state through a small bank of SBOX_COUNT
// aes_inv_sbox instances to perform InvSubBytes. The datapath area scales

---
 rtl/aes_inv_sub_bytes_seq.sv | 150 +++++++++++++++
 tb/tb_aes_inv_sub_bytes_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_sub_bytes_seq.sv
// rtl/aes_inv_sub_bytes_seq.sv - InvSubBytes over a 128-bit state using a small shared bank of inverse S-boxes

// Inverse S-box: inverse affine transform followed by the GF(2^8) multiplicative inverse (x^254)
module aes_inv_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ x;
            end
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] affine_inv;

    // Undo the forward affine map, then raise to the 254th power (0 maps to 0)
    always_comb begin
        logic [7:0] sq;
        logic [7:0] acc;
        affine_inv = {in_byte[6:0], in_byte[7]}
                   ^ {in_byte[4:0], in_byte[7:5]}
                   ^ {in_byte[1:0], in_byte[7:2]}
                   ^ 8'h05;
        sq  = affine_inv;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        out_byte = acc;
    end

endmodule

// Sequencer: walks the 16 state bytes through SBOX_COUNT S-boxes per cycle
module aes_inv_sub_bytes_seq #(
    parameter int SBOX_COUNT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int STEPS  = 16 / SBOX_COUNT;
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam bit LEGAL  = (SBOX_COUNT == 1) || (SBOX_COUNT == 2) || (SBOX_COUNT == 4)
                         || (SBOX_COUNT == 8) || (SBOX_COUNT == 16);

    if (!LEGAL) begin : g_illegal_sbox_count
        $error("aes_inv_sub_bytes_seq: SBOX_COUNT must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [STEP_W-1:0]   step_q;
    logic [127:0]        data_q;
    logic [127:0]        data_next;
    logic [7:0]          sbox_in  [SBOX_COUNT];
    logic [7:0]          sbox_out [SBOX_COUNT];

    for (genvar k = 0; k < SBOX_COUNT; k++) begin : g_sbox
        aes_inv_sbox u_sbox (
            .in_byte  (sbox_in[k]),
            .out_byte (sbox_out[k])
        );
    end

    // Route the current step's byte group into the bank and merge results back in place
    always_comb begin
        data_next = data_q;
        for (int k = 0; k < SBOX_COUNT; k++) begin
            sbox_in[k] = 8'h00;
        end
        for (int g = 0; g < STEPS; g++) begin
            if (step_q == STEP_W'(g)) begin
                for (int k = 0; k < SBOX_COUNT; k++) begin
                    sbox_in[k] = data_q[127 - 8*(g*SBOX_COUNT + k) -: 8];
                    data_next[127 - 8*(g*SBOX_COUNT + k) -: 8] = sbox_out[k];
                end
            end
        end
    end

    // Block FSM: capture, process STEPS groups, hold result until consumed; clear overrides all
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            data_q  <= '0;
        end else if (clear) begin
            state_q <= IDLE;
            step_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q  <= in_state;
                        step_q  <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    data_q <= data_next;
                    if (step_q == STEP_W'(STEPS - 1)) begin
                        state_q <= DONE;
                    end else begin
                        step_q <= step_q + STEP_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    step_q  <= '0;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_state = data_q;

endmodule

// File: tb/tb_aes_inv_sub_bytes_seq.sv
// tb/tb_aes_inv_sub_bytes_seq.sv - self-checking bench for aes_inv_sub_bytes_seq at N=1, 4 and 16
`timescale 1ns/1ps

module tb_aes_inv_sub_bytes_seq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clear;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] in_state;
    logic         in_ready  [3];
    logic         out_valid [3];
    logic         busy      [3];
    logic [127:0] out_state [3];

    int checks = 0;
    int errors = 0;
    int lat_req [3];
    int steps4 = 4;

    logic [7:0] inv_tbl [256];

    typedef struct {
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    aes_inv_sub_bytes_seq #(.SBOX_COUNT(1)) u_n1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_state(in_state), .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_state(out_state[0]), .busy(busy[0])
    );
    aes_inv_sub_bytes_seq #(.SBOX_COUNT(4)) u_n4 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_state(in_state), .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_state(out_state[1]), .busy(busy[1])
    );
    aes_inv_sub_bytes_seq #(.SBOX_COUNT(16)) u_n16 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready[2]),
        .in_state(in_state), .out_valid(out_valid[2]), .out_ready(out_ready),
        .out_state(out_state[2]), .busy(busy[2])
    );

    // Polynomial product then reduction modulo 0x11b
    function automatic int ref_mul(input int a, input int b);
        int p;
        p = 0;
        for (int i = 0; i < 8; i++) if (((b >> i) & 1) != 0) p = p ^ (a << i);
        for (int i = 14; i >= 8; i--) if (((p >> i) & 1) != 0) p = p ^ (32'h11b << (i - 8));
        return p & 255;
    endfunction

    function automatic int rotl8(input int v, input int n);
        return ((v << n) | (v >> (8 - n))) & 255;
    endfunction

    // Forward S-box by brute-force inverse search, then invert the table
    task automatic build_table();
        int inv;
        int b;
        for (int x = 0; x < 256; x++) begin
            inv = 0;
            if (x != 0) for (int y = 1; y < 256; y++) if (ref_mul(x, y) == 1) inv = y;
            b = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 'h63;
            inv_tbl[b] = x[7:0];
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = inv_tbl[s[127 - 8*i -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sync_all();
        in_valid = 1'b0;
        out_ready = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // One block into all three instances; measure latency and result, then release
    task automatic run_block(input logic [127:0] v, input logic [127:0] ev, input string tag);
        int lat [3];
        for (int j = 0; j < 3; j++) lat[j] = -1;
        in_state = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            for (int j = 0; j < 3; j++) if (out_valid[j] && lat[j] < 0) lat[j] = k;
        end
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("%s_lat_n%0d", tag, 16 / lat_req[j]), lat[j], lat_req[j]);
            chk($sformatf("%s_data_n%0d", tag, 16 / lat_req[j]), out_state[j], ev);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++)
            chk($sformatf("%s_release_n%0d", tag, 16 / lat_req[j]), {in_ready[j], out_valid[j]}, 2'b10);
    endtask

    initial begin
        logic [127:0] v;
        logic [127:0] ev;
        logic [127:0] b2b_in  [3];
        logic [127:0] b2b_exp [3];
        int           b2b_t   [3];
        int           acc;
        int           res;
        logic         pre;
        logic         ok;

        lat_req[0] = 16;
        lat_req[1] = 4;
        lat_req[2] = 1;
        rst_n = 1'b0;
        clear = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_state = '0;
        build_table();

        #1;
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("reset_out_valid_%0d", j), out_valid[j], 1'b0);
            chk($sformatf("reset_busy_%0d", j), busy[j], 1'b0);
            chk($sformatf("reset_in_ready_%0d", j), in_ready[j], 1'b1);
            chk($sformatf("reset_out_state_%0d", j), out_state[j], 128'h0);
        end
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        vecs[0] = '{128'h63636363_63636363_63636363_63636363, 128'h0};
        vecs[1] = '{128'h00010203_04050607_08090a0b_0c0d0e0f, 128'h52096ad5_3036a538_bf40a39e_81f3d7fb};
        vecs[2] = '{128'h0, {16{8'h52}}};
        for (int i = 3; i < 8; i++) begin
            vecs[i].din  = rand128();
            vecs[i].dout = model(vecs[i].din);
        end
        for (int i = 0; i < 8; i++) run_block(vecs[i].din, vecs[i].dout, $sformatf("vec%0d", i));

        // Backpressure on the N=4 instance
        sync_all();
        v = rand128();
        ev = model(v);
        in_state = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < steps4; k++) tick();
        chk("bp_valid_rise", out_valid[1], 1'b1);
        in_valid = 1'b1;
        in_state = ~v;
        ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (!(out_valid[1] && out_state[1] === ev && !in_ready[1])) ok = 1'b0;
        end
        chk("bp_stable", ok, 1'b1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release", {in_ready[1], out_valid[1]}, 2'b10);
        chk("bp_hold_data", out_state[1], ev);

        // Back-to-back on the N=4 instance: busy STEPS + done 1 + idle 1 per block
        sync_all();
        for (int i = 0; i < 3; i++) begin
            b2b_in[i]  = rand128();
            b2b_exp[i] = model(b2b_in[i]);
            b2b_t[i]   = 0;
        end
        in_valid = 1'b1;
        out_ready = 1'b1;
        in_state = b2b_in[0];
        acc = 0;
        res = 0;
        pre = in_ready[1];
        for (int c = 1; c <= 60 && res < 3; c++) begin
            tick();
            if (pre) begin
                acc++;
                in_state = (acc < 3) ? b2b_in[acc] : rand128();
            end
            if (out_valid[1]) begin
                chk($sformatf("b2b_data%0d", res), out_state[1], b2b_exp[res]);
                b2b_t[res] = c;
                res++;
            end
            pre = in_ready[1];
        end
        chk("b2b_count", res, 3);
        chk("b2b_gap1", b2b_t[1] - b2b_t[0], steps4 + 2);
        chk("b2b_gap2", b2b_t[2] - b2b_t[1], steps4 + 2);
        sync_all();

        // clear on the second BUSY cycle
        in_state = rand128();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear_idle", {in_ready[1], busy[1], out_valid[1]}, 3'b100);
        ok = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (out_valid[1]) ok = 1'b1;
        end
        chk("clear_no_valid", ok, 1'b0);
        v = rand128();
        run_block(v, model(v), "after_clear");

        // Async reset between edges: N=1 and N=4 mid-BUSY, N=16 in DONE
        in_state = rand128();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        for (int j = 0; j < 3; j++)
            chk($sformatf("async_rst_%0d", j), {out_valid[j], busy[j], in_ready[j], out_state[j]},
                {3'b001, 128'h0});
        @(negedge clk);
        rst_n = 1'b1;
        run_block(vecs[0].din, vecs[0].dout, "post_rst_t1");
        run_block(vecs[1].din, vecs[1].dout, "post_rst_t2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
